// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional MADD/MADDU accumulate (ops 6/7) is enabled by defining MDU_MADD_EN.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] L_MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] L_DIV_N  = 5'(DIV_CYCLES);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      r_state, w_state_d;
    logic [4:0]  r_cnt, w_cnt_d;
    logic [31:0] r_hi, w_hi_d;
    logic [31:0] r_lo, w_lo_d;
    logic [31:0] r_a, r_b;
    logic [2:0]  r_op;
    logic        w_latch;
    logic        w_is_mul, w_is_div;

    logic [63:0] w_prod_s, w_prod_u, w_result;
    logic        w_div_signed, w_neg_a, w_neg_b;
    logic [31:0] w_abs_a, w_abs_b, w_uquo, w_urem, w_quo, w_rem;

    always_comb begin
        w_is_mul = (op == 3'd0) || (op == 3'd1);
`ifdef MDU_MADD_EN
        w_is_mul = w_is_mul || (op == 3'd6) || (op == 3'd7);
`endif
        w_is_div = (op == 3'd2) || (op == 3'd3);
    end

    // 64x64 multiply keeps only the low 64 bits, which is the exact 32x32 product
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide via magnitudes; also handles 0x80000000 / -1 without overflow trouble
    assign w_div_signed = (r_op == 3'd2);
    assign w_neg_a      = w_div_signed && r_a[31];
    assign w_neg_b      = w_div_signed && r_b[31];
    assign w_abs_a      = w_neg_a ? (~r_a + 32'd1) : r_a;
    assign w_abs_b      = w_neg_b ? (~r_b + 32'd1) : r_b;
    assign w_uquo       = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a / w_abs_b;
    assign w_urem       = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a % w_abs_b;

    always_comb begin
        w_quo = (w_neg_a ^ w_neg_b) ? (~w_uquo + 32'd1) : w_uquo;
        w_rem = w_neg_a ? (~w_urem + 32'd1) : w_urem;
        if (r_b == 32'd0) begin
            w_quo = 32'hFFFF_FFFF;
            w_rem = r_a;
        end
    end

    always_comb begin
        w_result = {r_hi, r_lo};
        case (r_op)
            3'd0:       w_result = w_prod_s;
            3'd1:       w_result = w_prod_u;
            3'd2, 3'd3: w_result = {w_rem, w_quo};
`ifdef MDU_MADD_EN
            3'd6:       w_result = {r_hi, r_lo} + w_prod_s;
            3'd7:       w_result = {r_hi, r_lo} + w_prod_u;
`endif
            default:    w_result = {r_hi, r_lo};
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_hi_d    = r_hi;
        w_lo_d    = r_lo;
        w_latch   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    if (w_is_mul || w_is_div) begin
                        w_latch   = 1'b1;
                        w_state_d = StBusy;
                        w_cnt_d   = w_is_mul ? L_MULT_N : L_DIV_N;
                    end else if (op == 3'd4) begin
                        w_hi_d = A;
                    end else if (op == 3'd5) begin
                        w_lo_d = A;
                    end
                end
            end
            StBusy: begin
                if (r_cnt == 5'd1) begin
                    {w_hi_d, w_lo_d} = w_result;
                    w_state_d        = StIdle;
                    w_cnt_d          = 5'd0;
                end else begin
                    w_cnt_d = r_cnt - 5'd1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 5'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_hi    <= w_hi_d;
            r_lo    <= w_lo_d;
            if (w_latch) begin
                r_a  <= A;
                r_b  <= B;
                r_op <= op;
            end
        end
    end

    assign busy = (r_state == StBusy);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (MADD checks follow MDU_MADD_EN).
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op, scramble operands, and count sampled busy cycles until it drops
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mult;
        int cyc;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL mult_busy got=%0d exp=5", cyc); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL multu_busy got=%0d exp=5", cyc); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got=%h exp=2", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_div;
        int cyc;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL div_busy got=%0d exp=10", cyc); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0, cyc);
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0s_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0s_hi got=%h exp=fffffffb", hi); end
        run_op(3'd3, 32'd7, 32'd0, cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL divu0_busy got=%0d exp=10", cyc); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'd7) begin errors++; $display("FAIL divu0_hi got=%h exp=7", hi); end
    endtask

    task automatic test_ignore_while_busy;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; op = 3'd5; A = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtlo_ignored_lo got=%h exp=ffffffff", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mtlo_ignored_busy got=%b exp=1", busy); end
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        checks++; if (cyc != 8) begin errors++; $display("FAIL div_rest_busy got=%0d exp=8", cyc); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div100_lo got=%h exp=e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div100_hi got=%h exp=2", hi); end
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'hABCD;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (hi !== 32'hABCD) begin errors++; $display("FAIL mthi_hi got=%h exp=abcd", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy2 got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_op(3'd1, 32'h0001_0000, 32'h0001_0000, cyc);
        checks++; if (cyc != 5) begin errors++; $display("FAIL b2b1_busy got=%0d exp=5", cyc); end
        checks++; if ({hi, lo} !== 64'h1_0000_0000) begin errors++; $display("FAIL b2b1_hilo got=%h exp=100000000", {hi, lo}); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        checks++; if (cyc != 10) begin errors++; $display("FAIL b2b2_busy got=%0d exp=10", cyc); end
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL divmin_hi got=%h exp=0", hi); end
    endtask

    task automatic test_midop_reset;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'h1000; B = 32'h1000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rst_mid_hilo got=%h exp=0", {hi, lo}); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || lo !== 32'd0) begin
            errors++; $display("FAIL rst_after busy=%b lo=%h exp busy=0 lo=0", busy, lo);
        end
        run_op(3'd0, 32'd6, 32'd7, cyc);
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL mult67_lo got=%h exp=2a", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mult67_hi got=%h exp=0", hi); end
    endtask

    task automatic test_madd;
        int cyc;
        @(negedge clk);
        start = 1'b1; op = 3'd5; A = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (lo !== 32'd10) begin errors++; $display("FAIL mtlo_lo got=%h exp=a", lo); end
        run_op(3'd6, 32'd3, 32'd4, cyc);
`ifdef MDU_MADD_EN
        checks++; if (cyc != 5) begin errors++; $display("FAIL madd_busy got=%0d exp=5", cyc); end
        checks++; if (lo !== 32'd22) begin errors++; $display("FAIL madd_lo got=%h exp=16", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL madd_hi got=%h exp=0", hi); end
        run_op(3'd7, 32'hFFFF_FFFF, 32'd2, cyc);
        checks++; if ({hi, lo} !== 64'h2_0000_0014) begin errors++; $display("FAIL maddu_hilo got=%h exp=200000014", {hi, lo}); end
`else
        checks++; if (cyc != 0) begin errors++; $display("FAIL madd_nop_busy got=%0d exp=0", cyc); end
        checks++; if (lo !== 32'd10) begin errors++; $display("FAIL madd_nop_lo got=%h exp=a", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL madd_nop_hi got=%h exp=0", hi); end
        run_op(3'd7, 32'hFFFF_FFFF, 32'd2, cyc);
        checks++; if (cyc != 0 || {hi, lo} !== 64'd10) begin
            errors++; $display("FAIL maddu_nop busy_cycles=%0d hilo=%h exp 0 and a", cyc, {hi, lo});
        end
`endif
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        test_reset;
        test_mult;
        test_div;
        test_ignore_while_busy;
        test_back_to_back;
        test_midop_reset;
        test_madd;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
